ddr_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single DDR3 controller AXI port between `conv_unit` (requester 0) and `pool_unit` (requester 1). It replaces direct wiring of both units onto one bus. Read and write channels are arbitrated independently, and each grant is held for one full burst. No grant is issued before `ddr_init_done`.

---
 rtl/ddr_port_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// Two-requester (conv=0, pool=1) arbiter sharing one DDR AXI port; read and write
// channels arbitrated independently, grant held per burst. `DDR_ARB_FIXED_PRIO_EN: ties go to conv.
module ddr_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 4,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ddr_init_done,
  // requester 0 (conv)
  input  logic                r0_arvalid,
  input  logic [ADDR_W-1:0]   r0_araddr,
  input  logic [LEN_W-1:0]    r0_arlen,
  input  logic [ID_W-1:0]     r0_arid,
  input  logic                r0_arap,
  output logic                r0_arready,
  output logic                r0_rvalid,
  output logic                r0_rlast,
  output logic [DATA_W-1:0]   r0_rdata,
  input  logic                r0_awvalid,
  input  logic [ADDR_W-1:0]   r0_awaddr,
  input  logic [LEN_W-1:0]    r0_awlen,
  input  logic [ID_W-1:0]     r0_awid,
  input  logic                r0_awap,
  output logic                r0_awready,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic [DATA_W/8-1:0] r0_wstrb,
  output logic                r0_wready,
  output logic                r0_wlast,
  // requester 1 (pool)
  input  logic                r1_arvalid,
  input  logic [ADDR_W-1:0]   r1_araddr,
  input  logic [LEN_W-1:0]    r1_arlen,
  input  logic [ID_W-1:0]     r1_arid,
  input  logic                r1_arap,
  output logic                r1_arready,
  output logic                r1_rvalid,
  output logic                r1_rlast,
  output logic [DATA_W-1:0]   r1_rdata,
  input  logic                r1_awvalid,
  input  logic [ADDR_W-1:0]   r1_awaddr,
  input  logic [LEN_W-1:0]    r1_awlen,
  input  logic [ID_W-1:0]     r1_awid,
  input  logic                r1_awap,
  output logic                r1_awready,
  input  logic [DATA_W-1:0]   r1_wdata,
  input  logic [DATA_W/8-1:0] r1_wstrb,
  output logic                r1_wready,
  output logic                r1_wlast,
  // DDR controller port
  output logic                axi_arvalid,
  output logic [ADDR_W-1:0]   axi_araddr,
  output logic [LEN_W-1:0]    axi_arlen,
  output logic [ID_W-1:0]     axi_aruser_id,
  output logic                axi_aruser_ap,
  input  logic                axi_arready,
  input  logic                axi_rvalid,
  input  logic                axi_rlast,
  input  logic [ID_W-1:0]     axi_rid,
  input  logic [DATA_W-1:0]   axi_rdata,
  output logic                axi_awvalid,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic [LEN_W-1:0]    axi_awlen,
  output logic [ID_W-1:0]     axi_awuser_id,
  output logic                axi_awuser_ap,
  input  logic                axi_awready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wready,
  input  logic                axi_wusero_last,
  input  logic [ID_W-1:0]     axi_wusero_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ch_state_e;

  ch_state_e       rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic            rd_owner_q, rd_owner_d, wr_owner_q, wr_owner_d;
  logic [ID_W-1:0] rd_id_q, rd_id_d, wr_id_q, wr_id_d;
  logic            rd_tie, wr_tie;
  logic            rd_req_v, wr_req_v;
  logic            unused_ok;

`ifdef DDR_ARB_FIXED_PRIO_EN
  assign rd_tie = 1'b0;
  assign wr_tie = 1'b0;
`else
  logic rd_last_q, rd_last_d, wr_last_q, wr_last_d;
  assign rd_tie = ~rd_last_q;
  assign wr_tie = ~wr_last_q;
`endif

  // Address/data muxes follow the owner register even when idle.
  assign axi_araddr    = rd_owner_q ? r1_araddr : r0_araddr;
  assign axi_arlen     = rd_owner_q ? r1_arlen  : r0_arlen;
  assign axi_aruser_id = rd_owner_q ? r1_arid   : r0_arid;
  assign axi_aruser_ap = rd_owner_q ? r1_arap   : r0_arap;
  assign axi_awaddr    = wr_owner_q ? r1_awaddr : r0_awaddr;
  assign axi_awlen     = wr_owner_q ? r1_awlen  : r0_awlen;
  assign axi_awuser_id = wr_owner_q ? r1_awid   : r0_awid;
  assign axi_awuser_ap = wr_owner_q ? r1_awap   : r0_awap;
  assign axi_wdata     = wr_owner_q ? r1_wdata  : r0_wdata;
  assign axi_wstrb     = wr_owner_q ? r1_wstrb  : r0_wstrb;
  assign r0_rdata      = axi_rdata;
  assign r1_rdata      = axi_rdata;
  assign rd_req_v      = rd_owner_q ? r1_arvalid : r0_arvalid;
  assign wr_req_v      = wr_owner_q ? r1_awvalid : r0_awvalid;

  assign unused_ok = ^{axi_wusero_id, wr_id_q};

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_owner_d  = rd_owner_q;
    rd_id_d     = rd_id_q;
`ifndef DDR_ARB_FIXED_PRIO_EN
    rd_last_d   = rd_last_q;
`endif
    axi_arvalid = 1'b0;
    r0_arready  = 1'b0;
    r1_arready  = 1'b0;
    r0_rvalid   = 1'b0;
    r1_rvalid   = 1'b0;
    r0_rlast    = 1'b0;
    r1_rlast    = 1'b0;
    case (rd_state_q)
      IDLE: begin
        if (ddr_init_done && (r0_arvalid || r1_arvalid)) begin
          rd_owner_d = (r0_arvalid && r1_arvalid) ? rd_tie : r1_arvalid;
          rd_state_d = ADDR;
        end
      end
      ADDR: begin
        axi_arvalid = rd_req_v;
        r0_arready  = ~rd_owner_q & axi_arready;
        r1_arready  = rd_owner_q & axi_arready;
        if (rd_req_v && axi_arready) begin
          rd_id_d    = axi_aruser_id;
`ifndef DDR_ARB_FIXED_PRIO_EN
          rd_last_d  = rd_owner_q;
`endif
          rd_state_d = DATA;
        end
      end
      DATA: begin
        // Beats tagged with a foreign id are dropped, including their rlast.
        if (axi_rvalid && (axi_rid == rd_id_q)) begin
          r0_rvalid = ~rd_owner_q;
          r1_rvalid = rd_owner_q;
          r0_rlast  = ~rd_owner_q & axi_rlast;
          r1_rlast  = rd_owner_q & axi_rlast;
          if (axi_rlast) rd_state_d = IDLE;
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_owner_d  = wr_owner_q;
    wr_id_d     = wr_id_q;
`ifndef DDR_ARB_FIXED_PRIO_EN
    wr_last_d   = wr_last_q;
`endif
    axi_awvalid = 1'b0;
    r0_awready  = 1'b0;
    r1_awready  = 1'b0;
    r0_wready   = 1'b0;
    r1_wready   = 1'b0;
    r0_wlast    = 1'b0;
    r1_wlast    = 1'b0;
    case (wr_state_q)
      IDLE: begin
        if (ddr_init_done && (r0_awvalid || r1_awvalid)) begin
          wr_owner_d = (r0_awvalid && r1_awvalid) ? wr_tie : r1_awvalid;
          wr_state_d = ADDR;
        end
      end
      ADDR: begin
        axi_awvalid = wr_req_v;
        r0_awready  = ~wr_owner_q & axi_awready;
        r1_awready  = wr_owner_q & axi_awready;
        if (wr_req_v && axi_awready) begin
          wr_id_d    = axi_awuser_id;
`ifndef DDR_ARB_FIXED_PRIO_EN
          wr_last_d  = wr_owner_q;
`endif
          wr_state_d = DATA;
        end
      end
      DATA: begin
        r0_wready = ~wr_owner_q & axi_wready;
        r1_wready = wr_owner_q & axi_wready;
        r0_wlast  = ~wr_owner_q & axi_wusero_last;
        r1_wlast  = wr_owner_q & axi_wusero_last;
        if (axi_wready && axi_wusero_last) wr_state_d = IDLE;
      end
      default: wr_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= IDLE;
      wr_state_q <= IDLE;
      rd_owner_q <= 1'b0;
      wr_owner_q <= 1'b0;
      rd_id_q    <= '0;
      wr_id_q    <= '0;
`ifndef DDR_ARB_FIXED_PRIO_EN
      rd_last_q  <= 1'b1;
      wr_last_q  <= 1'b1;
`endif
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_owner_q <= rd_owner_d;
      wr_owner_q <= wr_owner_d;
      rd_id_q    <= rd_id_d;
      wr_id_q    <= wr_id_d;
`ifndef DDR_ARB_FIXED_PRIO_EN
      rd_last_q  <= rd_last_d;
      wr_last_q  <= wr_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: transaction-level channel model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ddr_port_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ddr_init_done = 1'b0;

  logic r0_arvalid = 0, r1_arvalid = 0, r0_arap = 0, r1_arap = 0;
  logic [ADDR_W-1:0] r0_araddr = '0, r1_araddr = '0, r0_awaddr = '0, r1_awaddr = '0;
  logic [LEN_W-1:0] r0_arlen = '0, r1_arlen = '0, r0_awlen = '0, r1_awlen = '0;
  logic [ID_W-1:0] r0_arid = '0, r1_arid = '0, r0_awid = '0, r1_awid = '0;
  logic r0_awvalid = 0, r1_awvalid = 0, r0_awap = 0, r1_awap = 0;
  logic [DATA_W-1:0] r0_wdata = '0, r1_wdata = '0;
  logic [DATA_W/8-1:0] r0_wstrb = '0, r1_wstrb = '0;
  logic r0_arready, r1_arready, r0_rvalid, r1_rvalid, r0_rlast, r1_rlast;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic r0_awready, r1_awready, r0_wready, r1_wready, r0_wlast, r1_wlast;

  logic axi_arvalid, axi_aruser_ap, axi_awvalid, axi_awuser_ap;
  logic [ADDR_W-1:0] axi_araddr, axi_awaddr;
  logic [LEN_W-1:0] axi_arlen, axi_awlen;
  logic [ID_W-1:0] axi_aruser_id, axi_awuser_id;
  logic [DATA_W-1:0] axi_wdata;
  logic [DATA_W/8-1:0] axi_wstrb;
  logic axi_arready = 0, axi_rvalid = 0, axi_rlast = 0;
  logic [ID_W-1:0] axi_rid = '0, axi_wusero_id = '0;
  logic [DATA_W-1:0] axi_rdata = '0;
  logic axi_awready = 0, axi_wready = 0, axi_wusero_last = 0;

  int n_total = 0;
  int n_pass = 0;

  ddr_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .ddr_init_done(ddr_init_done),
    .r0_arvalid(r0_arvalid), .r0_araddr(r0_araddr), .r0_arlen(r0_arlen), .r0_arid(r0_arid),
    .r0_arap(r0_arap), .r0_arready(r0_arready), .r0_rvalid(r0_rvalid), .r0_rlast(r0_rlast),
    .r0_rdata(r0_rdata), .r0_awvalid(r0_awvalid), .r0_awaddr(r0_awaddr), .r0_awlen(r0_awlen),
    .r0_awid(r0_awid), .r0_awap(r0_awap), .r0_awready(r0_awready), .r0_wdata(r0_wdata),
    .r0_wstrb(r0_wstrb), .r0_wready(r0_wready), .r0_wlast(r0_wlast),
    .r1_arvalid(r1_arvalid), .r1_araddr(r1_araddr), .r1_arlen(r1_arlen), .r1_arid(r1_arid),
    .r1_arap(r1_arap), .r1_arready(r1_arready), .r1_rvalid(r1_rvalid), .r1_rlast(r1_rlast),
    .r1_rdata(r1_rdata), .r1_awvalid(r1_awvalid), .r1_awaddr(r1_awaddr), .r1_awlen(r1_awlen),
    .r1_awid(r1_awid), .r1_awap(r1_awap), .r1_awready(r1_awready), .r1_wdata(r1_wdata),
    .r1_wstrb(r1_wstrb), .r1_wready(r1_wready), .r1_wlast(r1_wlast),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_aruser_id(axi_aruser_id), .axi_aruser_ap(axi_aruser_ap), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awuser_id(axi_awuser_id), .axi_awuser_ap(axi_awuser_ap), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_wusero_last(axi_wusero_last), .axi_wusero_id(axi_wusero_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel model: owner -1 means free; a grant lasts from arbitration to the
  // burst's final accepted beat. m_*rr is the requester that wins the next tie.
  int m_rown = -1, m_wown = -1;
  bit m_racc = 0, m_wacc = 0, m_rrr = 0, m_wrr = 0;
  logic [ID_W-1:0] m_rid = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rown = -1; m_wown = -1; m_racc = 0; m_wacc = 0; m_rrr = 0; m_wrr = 0; m_rid = '0;
    end else begin
      if (m_rown < 0) begin
        if (ddr_init_done && (r0_arvalid || r1_arvalid)) begin
          m_rown = (r0_arvalid && r1_arvalid) ? int'(m_rrr) : (r1_arvalid ? 1 : 0);
          m_racc = 0;
        end
      end else if (!m_racc) begin
        if ((m_rown == 1 ? r1_arvalid : r0_arvalid) && axi_arready) begin
          m_racc = 1;
          m_rid = (m_rown == 1) ? r1_arid : r0_arid;
`ifndef DDR_ARB_FIXED_PRIO_EN
          m_rrr = (m_rown == 0);
`endif
        end
      end else if (axi_rvalid && axi_rlast && axi_rid == m_rid) begin
        m_rown = -1; m_racc = 0;
      end
      if (m_wown < 0) begin
        if (ddr_init_done && (r0_awvalid || r1_awvalid)) begin
          m_wown = (r0_awvalid && r1_awvalid) ? int'(m_wrr) : (r1_awvalid ? 1 : 0);
          m_wacc = 0;
        end
      end else if (!m_wacc) begin
        if ((m_wown == 1 ? r1_awvalid : r0_awvalid) && axi_awready) begin
          m_wacc = 1;
`ifndef DDR_ARB_FIXED_PRIO_EN
          m_wrr = (m_wown == 0);
`endif
        end
      end else if (axi_wready && axi_wusero_last) begin
        m_wown = -1; m_wacc = 0;
      end
    end
  end

  logic e_arv, e_awv, rbeat;
  always @(negedge clk) begin
    e_arv = (m_rown >= 0) && !m_racc && (m_rown == 1 ? r1_arvalid : r0_arvalid);
    chk("axi_arvalid", axi_arvalid, e_arv);
    chk("r0_arready", r0_arready, m_rown == 0 && !m_racc && axi_arready);
    chk("r1_arready", r1_arready, m_rown == 1 && !m_racc && axi_arready);
    if (e_arv) begin
      chk("axi_araddr", axi_araddr, m_rown == 1 ? r1_araddr : r0_araddr);
      chk("axi_arlen", axi_arlen, m_rown == 1 ? r1_arlen : r0_arlen);
      chk("axi_aruser_id", axi_aruser_id, m_rown == 1 ? r1_arid : r0_arid);
      chk("axi_aruser_ap", axi_aruser_ap, m_rown == 1 ? r1_arap : r0_arap);
    end
    rbeat = m_racc && axi_rvalid && (axi_rid == m_rid);
    chk("r0_rvalid", r0_rvalid, rbeat && m_rown == 0);
    chk("r1_rvalid", r1_rvalid, rbeat && m_rown == 1);
    chk("r0_rlast", r0_rlast, rbeat && m_rown == 0 && axi_rlast);
    chk("r1_rlast", r1_rlast, rbeat && m_rown == 1 && axi_rlast);
    chk("r0_rdata", r0_rdata, axi_rdata);
    chk("r1_rdata", r1_rdata, axi_rdata);
    e_awv = (m_wown >= 0) && !m_wacc && (m_wown == 1 ? r1_awvalid : r0_awvalid);
    chk("axi_awvalid", axi_awvalid, e_awv);
    chk("r0_awready", r0_awready, m_wown == 0 && !m_wacc && axi_awready);
    chk("r1_awready", r1_awready, m_wown == 1 && !m_wacc && axi_awready);
    if (e_awv) begin
      chk("axi_awaddr", axi_awaddr, m_wown == 1 ? r1_awaddr : r0_awaddr);
      chk("axi_awlen", axi_awlen, m_wown == 1 ? r1_awlen : r0_awlen);
      chk("axi_awuser_id", axi_awuser_id, m_wown == 1 ? r1_awid : r0_awid);
      chk("axi_awuser_ap", axi_awuser_ap, m_wown == 1 ? r1_awap : r0_awap);
    end
    chk("r0_wready", r0_wready, m_wacc && m_wown == 0 && axi_wready);
    chk("r1_wready", r1_wready, m_wacc && m_wown == 1 && axi_wready);
    chk("r0_wlast", r0_wlast, m_wacc && m_wown == 0 && axi_wusero_last);
    chk("r1_wlast", r1_wlast, m_wacc && m_wown == 1 && axi_wusero_last);
    if (m_wacc) begin
      chk("axi_wdata", axi_wdata, m_wown == 1 ? r1_wdata : r0_wdata);
      chk("axi_wstrb", axi_wstrb, m_wown == 1 ? r1_wstrb : r0_wstrb);
    end
  end

  // Serve one read: accept the address, then return beats. Beat 'bad' carries a
  // foreign id with rlast set. 'waited' = cycles until axi_arvalid appeared.
  task automatic rd_txn(input int who, input int beats, input logic [ID_W-1:0] id,
                        input int bad, output int waited);
    waited = 0;
    while (!axi_arvalid && waited < 20) begin step(); waited++; end
    if (!axi_arvalid) begin chk("rd_grant_timeout", 0, 1); return; end
    axi_arready = 1;
    step();
    axi_arready = 0;
    if (who == 1) r1_arvalid = 0; else r0_arvalid = 0;
    for (int i = 0; i < beats; i++) begin
      axi_rvalid = 1;
      axi_rdata = {8{$urandom}};
      axi_rid = (i == bad) ? ~id : id;
      axi_rlast = (i == beats - 1) || (i == bad);
      if (i == bad) begin
        #1;
        chk("mismatch_beat_rvalid", {r0_rvalid, r1_rvalid, r0_rlast, r1_rlast}, 0);
      end
      step();
    end
    axi_rvalid = 0; axi_rlast = 0;
  endtask

  // Serve one write; 'granted' is the requester whose awready fired. abort_at >= 0
  // pulses reset low in the middle of that beat instead of finishing.
  task automatic wr_txn(input int beats, input int abort_at, output int granted);
    int w;
    w = 0;
    granted = 0;
    while (!axi_awvalid && w < 20) begin step(); w++; end
    if (!axi_awvalid) begin chk("wr_grant_timeout", 0, 1); return; end
    axi_awready = 1;
    #1;
    granted = r1_awready ? 1 : 0;
    step();
    axi_awready = 0;
    if (granted == 1) r1_awvalid = 0; else r0_awvalid = 0;
    for (int i = 0; i < beats; i++) begin
      r0_wdata = {8{$urandom}}; r1_wdata = {8{$urandom}};
      r0_wstrb = $urandom; r1_wstrb = $urandom;
      axi_wready = 1;
      axi_wusero_last = (i == beats - 1);
      if (i == abort_at) begin
        #1;
        chk("pre_abort_wready", {r0_wready, r1_wready}, granted == 1 ? 2'b01 : 2'b10);
        #1;
        rst_n = 0;
        #1;
        chk("abort_outputs_zero", {r0_arready, r1_arready, r0_rvalid, r1_rvalid, r0_rlast,
            r1_rlast, axi_arvalid, axi_awvalid, r0_awready, r1_awready, r0_wready, r1_wready,
            r0_wlast, r1_wlast}, 0);
        axi_wready = 0; axi_wusero_last = 0;
        return;
      end
      step();
    end
    axi_wready = 0; axi_wusero_last = 0;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
  endtask

  int w, g, ord[4], exp_ord[4];

  initial begin
`ifdef DDR_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 0, 1};
`endif
    r0_araddr = 28'hABCDEF0; r1_araddr = 28'h1234567;
    r0_awaddr = 28'h0A0A0A0; r1_awaddr = 28'h0B0B0B0;
    r0_awid = 4'h6; r1_awid = 4'h7; r1_arap = 1; r0_awap = 1;
    repeat (2) step();
    chk("reset_axi_arvalid", axi_arvalid, 0);
    chk("reset_axi_awvalid", axi_awvalid, 0);
    chk("reset_araddr_owner0", axi_araddr, 28'hABCDEF0);
    chk("reset_awaddr_owner0", axi_awaddr, 28'h0A0A0A0);
    rst_n = 1;

    // No grant before calibration; grant one cycle after ddr_init_done.
    r0_arvalid = 1; r0_arid = 4'h5; r0_arlen = 4'h0;
    repeat (4) step();
    chk("no_grant_before_init", axi_arvalid, 0);
    ddr_init_done = 1;
    #1;
    chk("grant_not_same_cycle", axi_arvalid, 0);
    step();
    chk("grant_after_init", axi_arvalid, 1);
    chk("grant_after_init_addr", axi_araddr, 28'hABCDEF0);
    rd_txn(0, 1, 4'h5, -1, w);
    chk("init_wait", w, 0);

    // Tie from reset: r0 first, r1 granted two cycles after r0's rlast.
    reset_dut();
    r0_arvalid = 1; r0_arlen = 4'd3; r0_arid = 4'h1;
    r1_arvalid = 1; r1_arlen = 4'd3; r1_arid = 4'h2;
    rd_txn(0, 4, 4'h1, -1, w);
    chk("tie_first_wait", w, 1);
    rd_txn(1, 4, 4'h2, -1, w);
    chk("r1_grant_gap", w, 1);

    // Repeated simultaneous writes.
    reset_dut();
    r0_awvalid = 1; r1_awvalid = 1; r0_awlen = 4'd3; r1_awlen = 4'd3;
    for (int r = 0; r < 4; r++) begin
      wr_txn(4, -1, g);
      ord[r] = g;
      if (r < 3) begin
        if (g == 1) r1_awvalid = 1; else r0_awvalid = 1;
      end
    end
    wr_txn(4, -1, g);
    for (int r = 0; r < 4; r++) chk($sformatf("wr_order_%0d", r), ord[r], exp_ord[r]);

    // Overlapped r0 read and r1 write, 8 beats each.
    step();
    r0_arvalid = 1; r0_arlen = 4'd7; r0_arid = 4'h9;
    r1_awvalid = 1; r1_awlen = 4'd7;
    fork
      rd_txn(0, 8, 4'h9, -1, w);
      wr_txn(8, -1, g);
    join
    chk("overlap_wr_owner", g, 1);
    chk("overlap_rd_wait", w, 1);

    // Foreign-id beat with rlast does not end the burst.
    step();
    r1_arvalid = 1; r1_arid = 4'h3; r1_arlen = 4'd3;
    rd_txn(1, 5, 4'h3, 1, w);
    step();
    chk("after_mismatch_idle", axi_arvalid, 0);

    // Reset mid write burst, then a fresh request is served.
    r0_awvalid = 1; r0_awlen = 4'd3;
    wr_txn(4, 2, g);
    r0_awvalid = 0; r1_awvalid = 0; r0_arvalid = 0; r1_arvalid = 0;
    step();
    rst_n = 1;
    r1_arvalid = 1; r1_arid = 4'h4; r1_arlen = 4'd1;
    rd_txn(1, 2, 4'h4, -1, w);
    chk("post_reset_grant_wait", w, 1);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
